// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: op encodings,
// FSM state encoding, datapath modes and an operand magnitude helper.
package rv32m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } core_mode_e;

  // Magnitude of v when it is to be read as signed, otherwise v unchanged.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring shift-subtract
// divide on unsigned magnitudes, one step per enabled cycle.
module muldiv_iter_core
  import rv32m_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  core_mode_e  load_mode,
  input  logic [63:0] load_acc,
  input  logic [31:0] load_opnd,
  input  logic        step_en,
  output logic [63:0] acc
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  core_mode_e  mode_q, mode_d;
  logic [32:0] sum;
  logic [32:0] diff;

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    acc_d  = acc_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    diff   = acc_q[63:31] - {1'b0, opnd_q};
    if (load) begin
      acc_d  = load_acc;
      opnd_d = load_opnd;
      mode_d = load_mode;
    end else if (step_en) begin
      if (mode_q == MODE_MUL) begin
        acc_d = {sum, acc_q[31:1]};
      end else if (!diff[32]) begin
        acc_d = {diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {acc_q[62:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state is assigned with <= so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= MODE_MUL;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, step counter, sign fixup and corner cases.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; only XLEN=32 is supported.
module muldiv_sequencer
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        neg_q, neg_d;
  logic        corner_q, corner_d;
  logic [31:0] corner_res_q, corner_res_d;
  logic [31:0] result_q, result_d;

  logic        is_div_in, is_rem_in, sgn1_in, sgn2_in, neg_in;
  logic        div0_in, ovf_in;
  logic [31:0] mag1_in, mag2_in;
  logic        core_load, core_step;
  core_mode_e  core_mode;
  logic [63:0] acc;
  logic [63:0] prod;
  logic [31:0] final_val;

  assign is_div_in = FUNCT3[2];
  assign is_rem_in = FUNCT3[2] & FUNCT3[1];
  assign sgn1_in   = (FUNCT3 == F3_MULH) | (FUNCT3 == F3_MULHSU) |
                     (FUNCT3 == F3_DIV)  | (FUNCT3 == F3_REM);
  assign sgn2_in   = (FUNCT3 == F3_MULH) | (FUNCT3 == F3_DIV) | (FUNCT3 == F3_REM);
  // Remainder follows the dividend sign; products and quotients follow sign1^sign2.
  assign neg_in    = is_rem_in ? (sgn1_in & OPERAND1[31]) :
                     (sgn1_in & OPERAND1[31]) ^ (sgn2_in & OPERAND2[31]);
  assign mag1_in   = abs_if(OPERAND1, sgn1_in);
  assign mag2_in   = abs_if(OPERAND2, sgn2_in);
  assign div0_in   = is_div_in && (OPERAND2 == 32'd0);
  assign ovf_in    = is_div_in && !FUNCT3[0] &&
                     (OPERAND1 == 32'h8000_0000) && (OPERAND2 == 32'hFFFF_FFFF);
  assign core_mode = is_div_in ? MODE_DIV : MODE_MUL;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  logic [1:0]         fast_prod_unused;
  logic [31:0]        fast_res;
  assign fast_prod        = $signed({sgn1_in & OPERAND1[31], OPERAND1}) *
                            $signed({sgn2_in & OPERAND2[31], OPERAND2});
  assign fast_prod_unused = fast_prod[65:64];
  assign fast_res         = (FUNCT3 == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`endif

  muldiv_iter_core u_core (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (core_load),
    .load_mode (core_mode),
    .load_acc  ({32'd0, is_div_in ? mag1_in : mag2_in}),
    .load_opnd (is_div_in ? mag2_in : mag1_in),
    .step_en   (core_step),
    .acc       (acc)
  );

  always_comb begin
    prod = neg_q ? -acc : acc;
    case (funct3_q)
      F3_MUL:                      final_val = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod[63:32];
      F3_DIV, F3_DIVU:             final_val = neg_q ? -acc[31:0] : acc[31:0];
      default:                     final_val = neg_q ? -acc[63:32] : acc[63:32];
    endcase
    if (corner_q) final_val = corner_res_q;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    funct3_d     = funct3_q;
    neg_d        = neg_q;
    corner_d     = corner_q;
    corner_res_d = corner_res_q;
    result_d     = result_q;
    core_load    = 1'b0;
    core_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !FLUSH) begin
          funct3_d = FUNCT3;
          neg_d    = neg_in;
          count_d  = 5'd0;
          corner_d = 1'b1;
          state_d  = ST_FIN;
          if (div0_in) begin
            corner_res_d = is_rem_in ? OPERAND1 : 32'hFFFF_FFFF;
          end else if (ovf_in) begin
            corner_res_d = is_rem_in ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_in) begin
            corner_res_d = fast_res;
`endif
          end else begin
            corner_d  = 1'b0;
            core_load = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        count_d   = count_q + 5'd1;
        if (count_q == 5'd31) state_d = ST_FIN;
      end
      ST_FIN: begin
        result_d = final_val;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      funct3_q     <= '0;
      neg_q        <= 1'b0;
      corner_q     <= 1'b0;
      corner_res_q <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      funct3_q     <= funct3_d;
      neg_q        <= neg_d;
      corner_q     <= corner_d;
      corner_res_q <= corner_res_d;
      result_q     <= result_d;
    end
  end

  // RESULT is live during FIN and then held in result_q until the next FIN.
  assign STALL  = RESET_N & (((state_q == ST_IDLE) & START & ~FLUSH) | (state_q == ST_RUN));
  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);
  assign RESULT = (state_q == ST_FIN) ? final_val : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; multiply latency follows
// whether MULDIV_FAST_MUL_EN is defined for the build.
module tb_muldiv_sequencer;
  import rv32m_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic        FLUSH;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .FUNCT3   (FUNCT3),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .FLUSH    (FLUSH),
    .STALL    (STALL),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge and follow it to DONE, checking latency, stall and busy
  // cycle counts, the result, the one-cycle DONE pulse and the held RESULT.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input bit hold);
    int lat;
    int stalls;
    int busys;
    lat = 0;
    stalls = 0;
    busys = 0;
    @(negedge CLK);
    FUNCT3 = f3;
    OPERAND1 = a;
    OPERAND2 = b;
    START = 1'b1;
    #1;
    while (DONE !== 1'b1 && lat < 60) begin
      if (STALL === 1'b1) stalls++;
      if (BUSY === 1'b1) busys++;
      @(negedge CLK);
      if (!hold) START = 1'b0;
      #1;
      lat++;
    end
    START = 1'b0;
    #1;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busys), 64'(exp_lat - 1));
    check({tag, "_result"}, 64'(RESULT), 64'(exp_res));
    @(negedge CLK);
    #1;
    check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
    check({tag, "_result_hold"}, 64'(RESULT), 64'(exp_res));
    check({tag, "_stall_after"}, 64'(STALL), 64'd0);
  endtask

  initial begin
    int dones;
    int busys;
    RESET_N = 1'b1;
    START = 1'b0;
    FLUSH = 1'b0;
    FUNCT3 = 3'd0;
    OPERAND1 = 32'd0;
    OPERAND2 = 32'd0;
    #2 RESET_N = 1'b0;
    #1;
    check("reset_stall", 64'(STALL), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_result", 64'(RESULT), 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 33, 32'd14, 1'b0);
    run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 33, 32'd2, 1'b0);
    run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
    run_op("mulh_min_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 1'b0);
    run_op("mulhu_max_2", F3_MULHU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'd1, 1'b0);
    run_op("mul_3_m5", F3_MUL, 32'd3, 32'hFFFF_FFFB, MUL_LAT, 32'hFFFF_FFF1, 1'b0);
    run_op("mulhsu_m1_2", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_5_0", F3_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_5_0", F3_REM, 32'd5, 32'd0, 1, 32'd5, 1'b0);

    // FLUSH together with START in IDLE: no stall and no op.
    @(negedge CLK);
    FUNCT3 = F3_DIVU;
    OPERAND1 = 32'd100;
    OPERAND2 = 32'd7;
    START = 1'b1;
    FLUSH = 1'b1;
    #1;
    check("flush_start_stall", 64'(STALL), 64'd0);
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    #1;
    check("flush_start_busy", 64'(BUSY), 64'd0);
    check("flush_start_done", 64'(DONE), 64'd0);

    // FLUSH in RUN cycle 10: back to IDLE, no DONE, previous RESULT kept.
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    #1;
    check("flush_run_busy_before", 64'(BUSY), 64'd1);
    @(negedge CLK);
    FLUSH = 1'b0;
    #1;
    check("flush_run_busy_after", 64'(BUSY), 64'd0);
    check("flush_run_stall_after", 64'(STALL), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE === 1'b1) dones++;
      @(negedge CLK);
      #1;
    end
    check("flush_run_no_done", 64'(dones), 64'd0);
    check("flush_run_result", 64'(RESULT), 64'd5);

    // START held through RUN and FIN must not launch a second op.
    run_op("divu_hold_start", F3_DIVU, 32'd100, 32'd7, 33, 32'd14, 1'b1);
    busys = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (BUSY === 1'b1) busys++;
      if (DONE === 1'b1) dones++;
      @(negedge CLK);
      #1;
    end
    check("hold_no_second_busy", 64'(busys), 64'd0);
    check("hold_no_second_done", 64'(dones), 64'd0);

    // Asynchronous reset between edges at RUN cycle 5.
    @(negedge CLK);
    FUNCT3 = F3_DIVU;
    OPERAND1 = 32'd100;
    OPERAND2 = 32'd7;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    check("midrun_busy_before", 64'(BUSY), 64'd1);
    #1 RESET_N = 1'b0;
    #1;
    check("midrun_reset_stall", 64'(STALL), 64'd0);
    check("midrun_reset_busy", 64'(BUSY), 64'd0);
    check("midrun_reset_done", 64'(DONE), 64'd0);
    check("midrun_reset_result", 64'(RESULT), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE === 1'b1) dones++;
      @(negedge CLK);
      #1;
    end
    check("midrun_no_done", 64'(dones), 64'd0);
    run_op("divu_6_3_after_reset", F3_DIVU, 32'd6, 32'd3, 33, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
